reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised register file for the 16-bit CPU datapath: two combinational read ports (rs, rt),
//  one clocked write port (rd), plus a per-register busy scoreboard for pipelined issue.
//  Decode claims a destination; writeback writes it and clears busy; issue reads busy to detect
//  RAW/WAW hazards. Sits between decode/issue and writeback; replaces the fixed 4x16 file.
// PARAMETERS
//  DATA_W    16  register width in bits
//  ADDR_W    2   register address width; NREGS = 2**ADDR_W
//  ZERO_REG  1   1: register 0 reads 0, ignores writes/claims, never busy; 0: ordinary register
// PORTS
//  Clock       in   1       system clock, all state updates on posedge
//  Reset       in   1       asynchronous, active-high; clears all registers and busy bits
//  rs          in   ADDR_W  read port A address
//  rt          in   ADDR_W  read port B address
//  rd          in   ADDR_W  write address (writeback)
//  WriteData   in   DATA_W  write data
//  RegWrite    in   1       write enable for rd
//  ClaimEn     in   1       request to mark ClaimAddr busy (issue of a producing instruction)
//  ClaimAddr   in   ADDR_W  destination being claimed
//  ReadRs      out  DATA_W  contents of rs
//  ReadRt      out  DATA_W  contents of rt
//  RsBusy      out  1       rs has an outstanding claim (RAW hazard)
//  RtBusy      out  1       rt has an outstanding claim (RAW hazard)
//  ClaimStall  out  1       ClaimEn && ClaimAddr busy (WAW); claim not accepted this cycle
//  BusyCount   out  ADDR_W+1 number of busy registers
// BEHAVIOUR
//  - Reset (async, any time incl. mid-claim): all regs=0, busy=0, BusyCount=0; outputs settle
//    combinationally: ReadRs=ReadRt=0, RsBusy=RtBusy=0, ClaimStall=0.
//  - Reads: combinational, zero latency, from stored array. rs==rt legal, both ports same value.
//  - Write: posedge Clock, RegWrite=1 -> reg[rd]<=WriteData, busy[rd]<=0. Visible on reads from
//    the following cycle (unless bypass enabled). Write to non-busy reg is legal, data updated.
//  - Claim: posedge, ClaimEn=1 and !ClaimStall -> busy[ClaimAddr]<=1. ClaimStall is combinational
//    from current busy bits; stalled claim has no effect, issue must hold and retry.
//  - Same-cycle write and claim, same reg: write clears, claim sets -> busy ends 1 (new producer
//    wins); ClaimStall evaluated on pre-edge busy (stalls if busy before the edge).
//  - Same-cycle write and claim, different regs: both take effect independently.
//  - BusyCount = popcount(busy), registered alongside busy bits; range 0..NREGS (no wrap).
//  - ZERO_REG=1: reg0 always reads 0, RegWrite to rd=0 dropped, ClaimEn to 0 accepted but sets
//    nothing, ClaimStall never asserted for address 0, RsBusy/RtBusy=0 for address 0.
//  - Address widths exact; no out-of-range addresses exist (NREGS = 2**ADDR_W).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: if RegWrite && rd==rs (resp. rt) && rd is writable, ReadRs (ReadRt)
//   = WriteData and RsBusy (RtBusy)=0 in the same cycle (write-through forwarding).
//  Not defined: reads return stored value; busy reflects pre-edge state; consumer waits 1 cycle.
// STRUCTURE
//  Shared package cpu_pkg: DATA_W/ADDR_W defaults, reg_addr_t and word_t typedefs, REG_ZERO const.
//  One sub-module: rf_scoreboard (busy bits, claim/clear arbitration, ClaimStall, BusyCount);
//  data array, read muxes and bypass stay in reg_file_sb.
// TESTING
//  1 Reset mid-run after writes/claims -> all ReadRs/ReadRt=0, BusyCount=0 immediately, pre-edge.
//  2 rd=1,WriteData=15,RegWrite pulse; rd=2,WriteData=9; then rs=1,rt=2 -> ReadRs=15, ReadRt=9.
//  3 Claim 3 (BusyCount=1, rs=3 -> RsBusy=1); claim 3 again -> ClaimStall=1, BusyCount stays 1;
//    write rd=3,WriteData=0xABCD -> RsBusy=0, ReadRs=0xABCD, BusyCount=0.
//  4 Busy reg 2, same cycle RegWrite rd=2 and ClaimEn 2 -> ClaimStall=1, busy cleared; with
//    reg 2 idle: same cycle write+claim -> busy[2]=1 after edge, data=written value.
//  5 ZERO_REG=1: write rd=0,WriteData=0x1234; claim 0 -> ReadRs(rs=0)=0, RsBusy=0, BusyCount=0.
//  6 Bypass: rs=rd=1, WriteData=7, RegWrite=1 -> with REGFILE_BYPASS_EN ReadRs=7 same cycle;
//    without it ReadRs=old value until after the edge. Claim all regs -> BusyCount=NREGS-ZERO_REG.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default widths, register address/word types
// and the hard-wired zero register address.
package cpu_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 2;

  typedef logic [DEFAULT_DATA_W-1:0] word_t;
  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = reg_addr_t'(0);

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: claims set busy, writeback clears it, and a claim
// to an already-busy register is stalled. BusyCount is registered with the busy bits.
module rf_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     clearEn,
  input  logic [ADDR_W-1:0]        clearAddr,
  input  logic                     ClaimEn,
  input  logic [ADDR_W-1:0]        ClaimAddr,
  output logic [(2**ADDR_W)-1:0]   busy,
  output logic                     ClaimStall,
  output logic [ADDR_W:0]          BusyCount
);

  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0] busyNext;
  logic [ADDR_W:0]  countNext;
  logic             claimHitsZero;

  // Clear is applied before set so a same-register write+claim leaves the new producer busy.
  // The stall uses pre-edge busy, so a stalled claim cannot re-set a bit the write clears.
  always_comb begin
    ClaimStall    = ClaimEn && busy[ClaimAddr];
    claimHitsZero = (ZERO_REG != 0) && (ClaimAddr == ADDR_W'(REG_ZERO));
    busyNext      = busy;
    if (clearEn) begin
      busyNext[clearAddr] = 1'b0;
    end
    if (ClaimEn && !ClaimStall && !claimHitsZero) begin
      busyNext[ClaimAddr] = 1'b1;
    end
    countNext = '0;
    for (int i = 0; i < NREGS; i++) begin
      countNext = countNext + {{ADDR_W{1'b0}}, busyNext[i]};
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      busy      <= '0;
      BusyCount <= '0;
    end else begin
      busy      <= busyNext;
      BusyCount <= countNext;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and clear busy) on matching reads.
module reg_file_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic              ClaimEn,
  input  logic [ADDR_W-1:0] ClaimAddr,
  output logic [DATA_W-1:0] ReadRs,
  output logic [DATA_W-1:0] ReadRt,
  output logic              RsBusy,
  output logic              RtBusy,
  output logic              ClaimStall,
  output logic [ADDR_W:0]   BusyCount
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic              rdWritable;
  logic              rsIsZero;
  logic              rtIsZero;

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) scoreboard (
    .Clock      (Clock),
    .Reset      (Reset),
    .clearEn    (RegWrite),
    .clearAddr  (rd),
    .ClaimEn    (ClaimEn),
    .ClaimAddr  (ClaimAddr),
    .busy       (busy),
    .ClaimStall (ClaimStall),
    .BusyCount  (BusyCount)
  );

  assign rdWritable = RegWrite && !((ZERO_REG != 0) && (rd == ADDR_W'(REG_ZERO)));
  assign rsIsZero   = (ZERO_REG != 0) && (rs == ADDR_W'(REG_ZERO));
  assign rtIsZero   = (ZERO_REG != 0) && (rt == ADDR_W'(REG_ZERO));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (rdWritable) begin
      regs[rd] <= WriteData;
    end
  end

  // Busy bits of a hard-wired zero register are never set, so busy[] needs no zero masking.
  always_comb begin
    ReadRs = rsIsZero ? '0 : regs[rs];
    ReadRt = rtIsZero ? '0 : regs[rt];
    RsBusy = busy[rs];
    RtBusy = busy[rt];
`ifdef REGFILE_BYPASS_EN
    if (rdWritable && (rd == rs)) begin
      ReadRs = WriteData;
      RsBusy = 1'b0;
    end
    if (rdWritable && (rd == rt)) begin
      ReadRt = WriteData;
      RtBusy = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (DATA_W=16, ADDR_W=2, ZERO_REG=1);
// expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_reg_file_sb;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [1:0]  rs, rt, rd, ClaimAddr;
  logic [15:0] WriteData;
  logic        RegWrite, ClaimEn;
  logic [15:0] ReadRs, ReadRt;
  logic        RsBusy, RtBusy, ClaimStall;
  logic [2:0]  BusyCount;

  int errorCount = 0;
  int checkCount = 0;

  reg_file_sb #(
    .DATA_W   (16),
    .ADDR_W   (2),
    .ZERO_REG (1)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .WriteData  (WriteData),
    .RegWrite   (RegWrite),
    .ClaimEn    (ClaimEn),
    .ClaimAddr  (ClaimAddr),
    .ReadRs     (ReadRs),
    .ReadRt     (ReadRt),
    .RsBusy     (RsBusy),
    .RtBusy     (RtBusy),
    .ClaimStall (ClaimStall),
    .BusyCount  (BusyCount)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] wAddr, input logic [15:0] wData,
                               input logic ce, input logic [1:0] cAddr);
    RegWrite  = we;
    rd        = wAddr;
    WriteData = wData;
    ClaimEn   = ce;
    ClaimAddr = cAddr;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0);
  endtask

  initial begin
    Reset = 1'b1;
    rs = 2'd0;
    rt = 2'd0;
    idle();
    #3;
    rs = 2'd1;
    rt = 2'd2;
    #1;
    checkOutput("resetReadRs", ReadRs, 0);
    checkOutput("resetBusyCount", BusyCount, 0);
    checkOutput("resetClaimStall", ClaimStall, 0);
    tick();
    Reset = 1'b0;
    tick();

    // Basic writes then reads
    applyStimulus(1'b1, 2'd1, 16'd15, 1'b0, 2'd0);
    tick();
    applyStimulus(1'b1, 2'd2, 16'd9, 1'b0, 2'd0);
    tick();
    idle();
    rs = 2'd1;
    rt = 2'd2;
    #1;
    checkOutput("readRs1", ReadRs, 15);
    checkOutput("readRt2", ReadRt, 9);
    rt = 2'd1;
    #1;
    checkOutput("sameAddrRt", ReadRt, 15);

    // Claim, WAW stall, writeback clears
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd3);
    tick();
    idle();
    rs = 2'd3;
    #1;
    checkOutput("claim3Busy", RsBusy, 1);
    checkOutput("claim3Count", BusyCount, 1);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd3);
    #1;
    checkOutput("wawStall", ClaimStall, 1);
    tick();
    idle();
    #1;
    checkOutput("stallCountHeld", BusyCount, 1);
    applyStimulus(1'b1, 2'd3, 16'hABCD, 1'b0, 2'd0);
    tick();
    idle();
    #1;
    checkOutput("wbClearBusy", RsBusy, 0);
    checkOutput("wbData", ReadRs, 16'hABCD);
    checkOutput("wbCount", BusyCount, 0);

    // Same-cycle write and claim on a busy register: stall, busy ends cleared
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd2);
    tick();
    applyStimulus(1'b1, 2'd2, 16'h1111, 1'b1, 2'd2);
    #1;
    checkOutput("busyWrClaimStall", ClaimStall, 1);
    tick();
    idle();
    rt = 2'd2;
    #1;
    checkOutput("busyWrClaimBusy", RtBusy, 0);
    checkOutput("busyWrClaimData", ReadRt, 16'h1111);
    checkOutput("busyWrClaimCount", BusyCount, 0);

    // Same-cycle write and claim on an idle register: new producer wins
    applyStimulus(1'b1, 2'd2, 16'h2222, 1'b1, 2'd2);
    #1;
    checkOutput("idleWrClaimStall", ClaimStall, 0);
    tick();
    idle();
    #1;
    checkOutput("idleWrClaimBusy", RtBusy, 1);
    checkOutput("idleWrClaimData", ReadRt, 16'h2222);
    checkOutput("idleWrClaimCount", BusyCount, 1);

    // Write and claim to different registers in the same cycle
    applyStimulus(1'b1, 2'd1, 16'h0055, 1'b1, 2'd3);
    tick();
    idle();
    rs = 2'd1;
    rt = 2'd3;
    #1;
    checkOutput("diffWrData", ReadRs, 16'h0055);
    checkOutput("diffClaimBusy", RtBusy, 1);
    checkOutput("diffCount", BusyCount, 2);

    // Register zero ignores writes and claims
    applyStimulus(1'b1, 2'd0, 16'h1234, 1'b0, 2'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd0);
    #1;
    checkOutput("zeroClaimStall", ClaimStall, 0);
    tick();
    idle();
    rs = 2'd0;
    #1;
    checkOutput("zeroRead", ReadRs, 0);
    checkOutput("zeroBusy", RsBusy, 0);
    checkOutput("zeroCount", BusyCount, 2);

    // Write-through forwarding on a same-cycle write
    rs = 2'd1;
    applyStimulus(1'b1, 2'd1, 16'd7, 1'b0, 2'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypassSameCycle", ReadRs, 7);
`else
    checkOutput("noBypassSameCycle", ReadRs, 16'h0055);
`endif
    tick();
    idle();
    #1;
    checkOutput("bypassAfterEdge", ReadRs, 7);

    // Drain then claim every register
    applyStimulus(1'b1, 2'd2, 16'h0002, 1'b0, 2'd0);
    tick();
    applyStimulus(1'b1, 2'd3, 16'h0003, 1'b0, 2'd0);
    tick();
    idle();
    #1;
    checkOutput("drainCount", BusyCount, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'(i));
      tick();
    end
    idle();
    #1;
    checkOutput("claimAllCount", BusyCount, 3);
    rs = 2'd1;
    applyStimulus(1'b1, 2'd1, 16'h0099, 1'b0, 2'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypassBusy", RsBusy, 0);
`else
    checkOutput("noBypassBusy", RsBusy, 1);
`endif
    tick();
    idle();
    #1;
    checkOutput("wbAfterAllCount", BusyCount, 2);

    // Asynchronous reset between edges
    rs = 2'd1;
    rt = 2'd2;
    #1;
    Reset = 1'b1;
    #1;
    checkOutput("asyncRstReadRs", ReadRs, 0);
    checkOutput("asyncRstReadRt", ReadRt, 0);
    checkOutput("asyncRstCount", BusyCount, 0);
    checkOutput("asyncRstRtBusy", RtBusy, 0);
    tick();
    Reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
